// File: rtl/cla_pkg.sv
// Shared definitions for the CLA BIST slice.
// Holds the controller state encoding, the default operand width and
// a helper that gives the width of a packed {a, b, cin} vector.
package cla_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed to hold one {a, b, cin} stimulus vector.
    function automatic int unsigned vec_w(input int unsigned width);
        return 2 * width + 1;
    endfunction

endpackage

// File: rtl/cla_bist_vecgen.sv
// Vector index generator for the CLA BIST controller.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         restart the index at 0 (wins over inc)
//   inc         advance the index by one
//   idx         current vector index, {a, b, cin} packed
//   last        idx is the final vector of the run
//   a, b, cin   idx split into adder operands (a in the MSBs)
module cla_bist_vecgen
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned NUM_VECTORS = 512
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      inc,
    output logic [vec_w(WIDTH)-1:0]   idx,
    output logic                      last,
    output logic [WIDTH-1:0]          a,
    output logic [WIDTH-1:0]          b,
    output logic                      cin
);

    localparam int unsigned VW = vec_w(WIDTH);
    localparam logic [VW-1:0] LAST_IDX = VW'(NUM_VECTORS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + VW'(1);
        end
    end

    assign last         = (idx == LAST_IDX);
    assign {a, b, cin}  = idx;

endmodule

// File: rtl/cla_bist_ctrl.sv
// Built-in self-test controller for a combinational CLA adder.
// Walks {a, b, cin} vectors onto the adder, compares {c3, s} against the
// arithmetic sum, counts mismatches (saturating) and captures the first
// failing vector.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, abort         run request / run cancel
//   dut_a, dut_b, dut_cin  stimulus to the adder
//   dut_s, dut_c3        adder result
//   busy, done, pass     run status
//   err_count            saturating mismatch count
//   fail_vec, fail_got   first failing {a,b,cin} and the {c3,s} seen there
module cla_bist_ctrl
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned NUM_VECTORS = 512,
    parameter int unsigned ERR_W       = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    output logic               dut_cin,
    input  logic [WIDTH-1:0]   dut_s,
    input  logic               dut_c3,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count,
    output logic [2*WIDTH:0]   fail_vec,
    output logic [WIDTH:0]     fail_got
);

    localparam int unsigned VW = vec_w(WIDTH);
    localparam int unsigned SW = WIDTH + 1;

    state_t            state, state_nxt;
    logic [VW-1:0]     idx;
    logic              last;
    logic [WIDTH-1:0]  va, vb;
    logic              vcin;
    logic [SW-1:0]     exp_q;
    logic              first_fail;
    logic              go, running, mism;

    assign running = (state == DRIVE) || (state == CHECK);
    // start is only honoured when no run is in flight; it also beats abort.
    assign go      = start && !running;
    assign mism    = ({dut_c3, dut_s} != exp_q);

    cla_bist_vecgen #(
        .WIDTH       (WIDTH),
        .NUM_VECTORS (NUM_VECTORS)
    ) u_vecgen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (go),
        .inc   ((state == CHECK) && !abort && !last),
        .idx   (idx),
        .last  (last),
        .a     (va),
        .b     (vb),
        .cin   (vcin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = running;
        done      = (state == DONE);
        pass      = (state == DONE) && (err_count == '0);
        case (state)
            IDLE, DONE: if (start) state_nxt = DRIVE;
            DRIVE:      state_nxt = abort ? IDLE : CHECK;
            CHECK: begin
                if (abort)     state_nxt = IDLE;
                else if (last) state_nxt = DONE;
                else           state_nxt = DRIVE;
            end
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_a      <= '0;
            dut_b      <= '0;
            dut_cin    <= 1'b0;
            exp_q      <= '0;
            err_count  <= '0;
            fail_vec   <= '0;
            fail_got   <= '0;
            first_fail <= 1'b0;
        end else if (go) begin
            err_count  <= '0;
            fail_vec   <= '0;
            fail_got   <= '0;
            first_fail <= 1'b0;
        end else if (!abort) begin
            if (state == DRIVE) begin
                dut_a   <= va;
                dut_b   <= vb;
                dut_cin <= vcin;
                exp_q   <= SW'(va) + SW'(vb) + SW'(vcin);
            end else if ((state == CHECK) && mism) begin
                if (err_count != '1) err_count <= err_count + ERR_W'(1);
                if (!first_fail) begin
                    first_fail <= 1'b1;
                    fail_vec   <= idx;
                    fail_got   <= {dut_c3, dut_s};
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_bist_ctrl.sv
module tb_cla_bist_ctrl;

    logic clk = 1'b0;
    logic rst_n, start0, abort0, start1, abort1;

    logic [3:0] a0, b0, s0;
    logic       cin0, c30, busy0, done0, pass0;
    logic [9:0] err0;
    logic [8:0] fvec0;
    logic [4:0] fgot0;

    logic [3:0] a1, b1, s1;
    logic       cin1, c31, busy1, done1, pass1;
    logic [1:0] err1;
    logic [8:0] fvec1;
    logic [4:0] fgot1;

    int mode0, mode1;
    logic [4:0] fmask [512];
    logic [4:0] r0, r1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Adder models: golden sum with an optional planted fault.
    always_comb begin
        r0 = 5'(a0) + 5'(b0) + 5'(cin0);
        case (mode0)
            1:       r0[0] = 1'b0;
            2:       r0[4] = 1'b0;
            3:       r0 = r0 ^ fmask[{a0, b0, cin0}];
            default: ;
        endcase
    end
    assign {c30, s0} = r0;

    always_comb begin
        r1 = 5'(a1) + 5'(b1) + 5'(cin1);
        if (mode1 == 1) r1[0] = 1'b0;
    end
    assign {c31, s1} = r1;

    cla_bist_ctrl #(.WIDTH(4), .NUM_VECTORS(512), .ERR_W(10)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .dut_a(a0), .dut_b(b0), .dut_cin(cin0), .dut_s(s0), .dut_c3(c30),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .fail_vec(fvec0), .fail_got(fgot0)
    );

    cla_bist_ctrl #(.WIDTH(4), .NUM_VECTORS(10), .ERR_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .dut_a(a1), .dut_b(b1), .dut_cin(cin1), .dut_s(s1), .dut_c3(c31),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .fail_vec(fvec1), .fail_got(fgot1)
    );

    typedef struct {
        int mode;
        int err;
        int fvec;
        int fgot;
        int pass;
    } rec_t;

    rec_t tbl [3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the vector space arithmetically, apply the planted
    // fault, count mismatches with saturation and note the first one.
    function automatic void model(input int m, input int n, input int ew,
                                  output int err, output int fv, output int fg);
        int  sat;
        bit  seen;
        err  = 0; fv = 0; fg = 0; seen = 0;
        sat  = (1 << ew) - 1;
        for (int i = 0; i < n; i++) begin
            int a, b, c, good, got;
            a    = i / 32;
            b    = (i / 2) % 16;
            c    = i % 2;
            good = a + b + c;
            got  = good;
            if (m == 1)      got = good & ~1;
            else if (m == 2) got = good & 15;
            else if (m == 3) got = good ^ int'(fmask[i]);
            if (got != good) begin
                if (!seen) begin
                    seen = 1; fv = i; fg = got;
                end
                if (err < sat) err++;
            end
        end
    endfunction

    // Pulse start on u0 and count cycles until done, bounded.
    task automatic run0(output int n);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        n = 1;
        check("busy_after_start", 32'(busy0), 1);
        while (!done0 && n < 3000) begin
            step();
            n++;
        end
        check("run0_done_in_time", 32'(done0), 1);
    endtask

    task automatic run1();
        int n;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 200) begin
            step();
            n++;
        end
        check("run1_done_in_time", 32'(done1), 1);
    endtask

    initial begin
        int n, e_err, e_fv, e_fg;

        tbl[0] = '{mode: 0, err: 0,   fvec: 0,  fgot: 0, pass: 1};
        tbl[1] = '{mode: 1, err: 256, fvec: 1,  fgot: 0, pass: 0};
        tbl[2] = '{mode: 2, err: 256, fvec: 31, fgot: 0, pass: 0};

        for (int i = 0; i < 512; i++) fmask[i] = '0;
        mode0 = 0; mode1 = 0;
        start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
        rst_n = 1'b0;
        step();
        step();
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_pass", 32'(pass0), 0);
        check("rst_ports", 32'({a0, b0, cin0}), 0);
        check("rst_err", 32'(err0), 0);
        check("rst_fvec", 32'(fvec0), 0);
        check("rst_fgot", 32'(fgot0), 0);
        rst_n = 1'b1;
        step();
        check("idle_busy", 32'(busy0), 0);

        // Golden run with exact done latency.
        run0(n);
        check("done_latency", 32'(n), 1025);
        check("golden_pass", 32'(pass0), 1);
        check("golden_err", 32'(err0), 0);
        check("golden_busy_at_done", 32'(busy0), 0);

        // Fixed fault table.
        for (int t = 0; t < 3; t++) begin
            mode0 = tbl[t].mode;
            run0(n);
            check("tbl_err",  32'(err0),  32'(tbl[t].err));
            check("tbl_fvec", 32'(fvec0), 32'(tbl[t].fvec));
            check("tbl_fgot", 32'(fgot0), 32'(tbl[t].fgot));
            check("tbl_pass", 32'(pass0), 32'(tbl[t].pass));
            check("tbl_latency", 32'(n), 1025);
        end

        // done is held while idle in DONE, and abort there has no effect.
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        step();
        check("done_held", 32'(done0), 1);
        check("err_held", 32'(err0), 256);

        // Random fault patterns against the reference model.
        mode0 = 3;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 512; i++)
                fmask[i] = ($urandom_range(0, 15) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            model(3, 512, 10, e_err, e_fv, e_fg);
            run0(n);
            check("rnd_err",  32'(err0),  32'(e_err));
            check("rnd_fvec", 32'(fvec0), 32'(e_fv));
            check("rnd_fgot", 32'(fgot0), 32'(e_fg));
            check("rnd_pass", 32'(pass0), 32'(e_err == 0));
        end

        // Abort mid-run, then a clean rerun started together with abort.
        mode0 = 0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 99; i++) step();
        check("pre_abort_busy", 32'(busy0), 1);
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        check("abort_busy", 32'(busy0), 0);
        check("abort_done", 32'(done0), 0);
        check("abort_pass", 32'(pass0), 0);
        step();
        step();
        check("abort_stays_idle", 32'(busy0), 0);
        start0 = 1'b1;
        abort0 = 1'b1;
        step();
        start0 = 1'b0;
        abort0 = 1'b0;
        check("start_beats_abort", 32'(busy0), 1);
        n = 1;
        while (!done0 && n < 3000) begin
            step();
            n++;
        end
        check("rerun_latency", 32'(n), 1025);
        check("rerun_pass", 32'(pass0), 1);

        // Short run: port sequence, ignored restart, done timing.
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            check("short_busy", 32'(busy1), 32'(cyc <= 20));
            check("short_done", 32'(done1), 32'(cyc == 21));
            if (cyc >= 2) check("short_idx", 32'({a1, b1, cin1}), 32'((cyc - 2) / 2));
            if (cyc == 4) start1 = 1'b1;
            if (cyc == 5) start1 = 1'b0;
            if (cyc < 21) step();
        end
        check("short_pass", 32'(pass1), 1);

        // Short run with saturating error counter.
        mode1 = 1;
        model(1, 10, 2, e_err, e_fv, e_fg);
        run1();
        check("sat_err",  32'(err1),  32'(e_err));
        check("sat_fvec", 32'(fvec1), 32'(e_fv));
        check("sat_fgot", 32'(fgot1), 32'(e_fg));
        check("sat_pass", 32'(pass1), 0);

        // Asynchronous reset in the middle of a faulty run.
        mode0 = 1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int i = 0; i < 200; i++) step();
        check("pre_rst_err_nonzero", 32'(err0 != 0), 1);
        rst_n = 1'b0;
        #2;
        check("arst_busy", 32'(busy0), 0);
        check("arst_ports", 32'({a0, b0, cin0}), 0);
        check("arst_err", 32'(err0), 0);
        check("arst_fvec", 32'(fvec0), 0);
        check("arst_fgot", 32'(fgot0), 0);
        check("arst_done_pass", 32'({done1, pass1, done0, pass0}), 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("post_rst_idle", 32'(busy0), 0);
        check("post_rst_ports", 32'({a0, b0, cin0}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
